// File: rtl/ex_fwd_stage.sv
// ID/EX pipeline register with execute-operand forwarding muxes and a two-deep
// writer history (s1 = EX/M, s2 = M/WB) that feeds the forwarding control unit.
module ex_fwd_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wrx,
  input  logic              id_memrd,
  input  logic              id_imm,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_immval,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic              forward_mem,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] ex_src1,
  output logic [REG_AW-1:0] ex_src2,
  output logic              ex_imm,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic              ex_valid,
  output logic [REG_AW-1:0] dest_s,
  output logic              wrx_s,
  output logic              memrd_s,
  output logic [DATA_W-1:0] res_s,
  output logic [REG_AW-1:0] dest_s2,
  output logic              wrx_s2,
  output logic              stall
);

  // ID/EX slot
  logic              ex_valid_reg;
  logic [REG_AW-1:0] ex_src1_reg;
  logic [REG_AW-1:0] ex_src2_reg;
  logic [REG_AW-1:0] ex_dest_reg;
  logic              ex_wrx_reg;
  logic              ex_memrd_reg;
  logic              ex_imm_reg;
  logic [DATA_W-1:0] ex_rdata1_reg;
  logic [DATA_W-1:0] ex_rdata2_reg;
  logic [DATA_W-1:0] ex_immval_reg;

  // Writer history
  logic              s1_valid_reg;
  logic [REG_AW-1:0] s1_dest_reg;
  logic              s1_wrx_reg;
  logic              s1_memrd_reg;
  logic [DATA_W-1:0] s1_res_reg;
  logic              s2_valid_reg;
  logic [REG_AW-1:0] s2_dest_reg;
  logic              s2_wrx_reg;

  // A taken branch kills the load-use hazard, since the dependent op is discarded.
  assign stall = ex_valid_reg & forward_mem & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg  <= 1'b0;
      ex_src1_reg   <= '0;
      ex_src2_reg   <= '0;
      ex_dest_reg   <= '0;
      ex_wrx_reg    <= 1'b0;
      ex_memrd_reg  <= 1'b0;
      ex_imm_reg    <= 1'b0;
      ex_rdata1_reg <= '0;
      ex_rdata2_reg <= '0;
      ex_immval_reg <= '0;
      s1_valid_reg  <= 1'b0;
      s1_dest_reg   <= '0;
      s1_wrx_reg    <= 1'b0;
      s1_memrd_reg  <= 1'b0;
      s1_res_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_dest_reg   <= '0;
      s2_wrx_reg    <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_dest_reg  <= s1_dest_reg;
      s2_wrx_reg   <= s1_wrx_reg;

      if (stall) begin
        s1_valid_reg <= 1'b0;
        s1_dest_reg  <= '0;
        s1_wrx_reg   <= 1'b0;
        s1_memrd_reg <= 1'b0;
        s1_res_reg   <= '0;
      end else begin
        s1_valid_reg <= ex_valid_reg;
        s1_dest_reg  <= ex_dest_reg;
        s1_wrx_reg   <= ex_wrx_reg;
        s1_memrd_reg <= ex_memrd_reg;
        s1_res_reg   <= alu_result;
      end

      // Bubbles carry all-zero fields so they can never match in forward_ct.
      if (flush || (!stall && !id_valid)) begin
        ex_valid_reg  <= 1'b0;
        ex_src1_reg   <= '0;
        ex_src2_reg   <= '0;
        ex_dest_reg   <= '0;
        ex_wrx_reg    <= 1'b0;
        ex_memrd_reg  <= 1'b0;
        ex_imm_reg    <= 1'b0;
        ex_rdata1_reg <= '0;
        ex_rdata2_reg <= '0;
        ex_immval_reg <= '0;
      end else if (!stall) begin
        ex_valid_reg  <= 1'b1;
        ex_src1_reg   <= id_src1;
        ex_src2_reg   <= id_src2;
        ex_dest_reg   <= id_dest;
        ex_wrx_reg    <= id_wrx;
        ex_memrd_reg  <= id_memrd;
        ex_imm_reg    <= id_imm;
        ex_rdata1_reg <= id_rdata1;
        ex_rdata2_reg <= id_rdata2;
        ex_immval_reg <= id_immval;
      end
    end
  end

  logic [1:0]        fwd_sel [2];
  logic [DATA_W-1:0] rf_data [2];
  logic [DATA_W-1:0] op_mux  [2];

  assign fwd_sel[0] = forward_a;
  assign fwd_sel[1] = forward_b;
  assign rf_data[0] = ex_rdata1_reg;
  assign rf_data[1] = ex_rdata2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opmux
      always_comb begin
        op_mux[gi] = rf_data[gi];
        case (fwd_sel[gi])
          2'd1:    op_mux[gi] = s1_res_reg;
          2'd2:    op_mux[gi] = wb_data;
          default: op_mux[gi] = rf_data[gi];
        endcase
      end
    end
  endgenerate

  assign ex_opa   = op_mux[0];
  assign ex_opb   = ex_imm_reg ? ex_immval_reg : op_mux[1];

  assign ex_src1  = ex_src1_reg;
  assign ex_src2  = ex_src2_reg;
  assign ex_imm   = ex_imm_reg;
  assign ex_valid = ex_valid_reg;
  assign dest_s   = s1_dest_reg;
  assign wrx_s    = s1_valid_reg & s1_wrx_reg;
  assign memrd_s  = s1_valid_reg & s1_memrd_reg;
  assign res_s    = s1_res_reg;
  assign dest_s2  = s2_dest_reg;
  assign wrx_s2   = s2_valid_reg & s2_wrx_reg;

endmodule

// File: tb/tb_ex_fwd_stage.sv
// Bench for ex_fwd_stage: directed load-use/flush/forwarding scenarios, then random
// traffic, all compared every cycle against a behavioural pipeline model.
module tb_ex_fwd_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_wrx, id_memrd, id_imm;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic [15:0] id_rdata1, id_rdata2, id_immval;
  logic [1:0]  forward_a, forward_b;
  logic        forward_mem, flush;
  logic [15:0] alu_result, wb_data;
  logic [3:0]  ex_src1, ex_src2, dest_s, dest_s2;
  logic        ex_imm, ex_valid, wrx_s, memrd_s, wrx_s2, stall;
  logic [15:0] ex_opa, ex_opb, res_s;

  ex_fwd_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_dest(id_dest), .id_wrx(id_wrx), .id_memrd(id_memrd), .id_imm(id_imm),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_immval(id_immval),
    .forward_a(forward_a), .forward_b(forward_b), .forward_mem(forward_mem),
    .flush(flush), .alu_result(alu_result), .wb_data(wb_data),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_opa(ex_opa),
    .ex_opb(ex_opb), .ex_valid(ex_valid), .dest_s(dest_s), .wrx_s(wrx_s),
    .memrd_s(memrd_s), .res_s(res_s), .dest_s2(dest_s2), .wrx_s2(wrx_s2),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  s1, s2, d;
    logic        wrx, memrd, imm;
    logic [15:0] r1, r2, iv;
  } instr_t;

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        wrx, memrd;
    logic [15:0] res;
  } stage_t;

  instr_t m_id;
  stage_t m_s1, m_s2;
  int     checks = 0;
  int     errors = 0;
  bit     chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stage_t retire(input instr_t i, input logic [15:0] res);
    stage_t s;
    s.v = i.v; s.d = i.d; s.wrx = i.wrx; s.memrd = i.memrd; s.res = res;
    return s;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    instr_t bubble_i, nxt;
    stage_t bubble_s;
    bit     hold;
    bubble_i = '{default: '0};
    bubble_s = '{default: '0};
    hold = m_id.v && forward_mem && !flush;
    if (rst) begin
      m_id = bubble_i; m_s1 = bubble_s; m_s2 = bubble_s;
    end else begin
      m_s2 = m_s1;
      m_s1 = hold ? bubble_s : retire(m_id, alu_result);
      if (flush) m_id = bubble_i;
      else if (!hold) begin
        nxt = '{v: 1'b1, s1: id_src1, s2: id_src2, d: id_dest, wrx: id_wrx,
                memrd: id_memrd, imm: id_imm, r1: id_rdata1, r2: id_rdata2, iv: id_immval};
        m_id = id_valid ? nxt : bubble_i;
      end
    end
  endtask

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] rf);
    if (sel == 2'd1) return m_s1.res;
    if (sel == 2'd2) return wb_data;
    return rf;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_valid", 32'(ex_valid), 32'(m_id.v));
      chk("ex_src1",  32'(ex_src1),  32'(m_id.s1));
      chk("ex_src2",  32'(ex_src2),  32'(m_id.s2));
      chk("ex_imm",   32'(ex_imm),   32'(m_id.imm));
      chk("ex_opa",   32'(ex_opa),   32'(pick(forward_a, m_id.r1)));
      chk("ex_opb",   32'(ex_opb),   32'(m_id.imm ? m_id.iv : pick(forward_b, m_id.r2)));
      chk("dest_s",   32'(dest_s),   32'(m_s1.d));
      chk("wrx_s",    32'(wrx_s),    32'(m_s1.v & m_s1.wrx));
      chk("memrd_s",  32'(memrd_s),  32'(m_s1.v & m_s1.memrd));
      chk("res_s",    32'(res_s),    32'(m_s1.res));
      chk("dest_s2",  32'(dest_s2),  32'(m_s2.d));
      chk("wrx_s2",   32'(wrx_s2),   32'(m_s2.v & m_s2.wrx));
      chk("stall",    32'(stall),    32'(m_id.v & forward_mem & ~flush));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_inputs();
    id_valid    = ($urandom_range(3) != 0);
    id_src1     = 4'($urandom_range(15));
    id_src2     = 4'($urandom_range(15));
    id_dest     = 4'($urandom_range(15));
    id_wrx      = 1'($urandom_range(1));
    id_memrd    = 1'($urandom_range(1));
    id_imm      = 1'($urandom_range(1));
    id_rdata1   = 16'($urandom);
    id_rdata2   = 16'($urandom);
    id_immval   = 16'($urandom);
    forward_a   = 2'($urandom_range(3));
    forward_b   = 2'($urandom_range(3));
    forward_mem = ($urandom_range(3) == 0);
    flush       = ($urandom_range(7) == 0);
    alu_result  = 16'($urandom);
    wb_data     = 16'($urandom);
  endtask

  task automatic idle();
    id_valid = 0; id_wrx = 0; id_memrd = 0; id_imm = 0;
    forward_a = 0; forward_b = 0; forward_mem = 0; flush = 0;
  endtask

  initial begin
    m_id = '{default: '0}; m_s1 = '{default: '0}; m_s2 = '{default: '0};
    rst = 1;
    rand_inputs();
    // T1: reset with random inputs
    cyc();
    chk_en = 1;
    rand_inputs();
    cyc();
    @(negedge clk);
    chk("t1_ex_valid", 32'(ex_valid), 32'd0);
    chk("t1_stall",    32'(stall),    32'd0);
    chk("t1_res_s",    32'(res_s),    32'd0);
    chk("t1_wrx_s2",   32'(wrx_s2),   32'd0);
    rst = 0; idle();
    cyc();
    @(negedge clk);
    chk("t1_ex_valid_idle", 32'(ex_valid), 32'd0);

    // T2: r1 result in s1 forwarded to operand A
    id_valid = 1; id_dest = 1; id_wrx = 1; id_src1 = 2; id_src2 = 3; id_rdata1 = 16'h0011;
    cyc();
    id_valid = 1; id_src1 = 1; id_src2 = 5; id_dest = 6; id_wrx = 1;
    id_rdata1 = 16'hAAAA; id_rdata2 = 16'h5555; alu_result = 16'h0005;
    cyc();
    idle(); forward_a = 1;
    @(negedge clk);
    chk("t2_res_s",  32'(res_s),  32'h0005);
    chk("t2_ex_opa", 32'(ex_opa), 32'h0005);
    chk("t2_dest_s", 32'(dest_s), 32'd1);

    // T3: both operands from wb_data
    #1; wb_data = 16'h1234; forward_a = 2; forward_b = 2;
    #1;
    chk("t3_ex_opa", 32'(ex_opa), 32'h1234);
    chk("t3_ex_opb", 32'(ex_opb), 32'h1234);

    // T4: load r3, then add r4 = r3 + r2 -> one-cycle stall
    cyc();
    idle(); id_valid = 1; id_dest = 3; id_wrx = 1; id_memrd = 1; id_src1 = 7;
    cyc();
    idle(); id_valid = 1; id_src1 = 3; id_src2 = 2; id_dest = 4; id_wrx = 1;
    id_rdata1 = 16'h0BAD;
    cyc();
    idle(); forward_mem = 1; id_valid = 1; id_src1 = 9;
    @(negedge clk);
    chk("t4_stall",   32'(stall),   32'd1);
    chk("t4_memrd_s", 32'(memrd_s), 32'd1);
    cyc();
    idle(); forward_a = 2; wb_data = 16'hBEEF;
    @(negedge clk);
    chk("t4_stall_once", 32'(stall),   32'd0);
    chk("t4_bubble",     32'(wrx_s),   32'd0);
    chk("t4_held_src1",  32'(ex_src1), 32'd3);
    chk("t4_dest_s2",    32'(dest_s2), 32'd3);
    chk("t4_ex_opa",     32'(ex_opa),  32'hBEEF);

    // T5: immediate overrides forward_b
    cyc();
    idle(); id_valid = 1; id_imm = 1; id_immval = 16'hFFF0; id_rdata2 = 16'h1111;
    cyc();
    idle(); forward_b = 1;
    @(negedge clk);
    chk("t5_ex_opb", 32'(ex_opb), 32'hFFF0);

    // T6: flush beats forward_mem; reset during a stall
    #1; forward_mem = 1; flush = 1; id_valid = 1;
    #1;
    chk("t6_stall", 32'(stall), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("t6_ex_valid", 32'(ex_valid), 32'd0);
    #1; id_valid = 1; id_wrx = 1; id_dest = 5;
    cyc();
    idle(); forward_mem = 1;
    @(negedge clk);
    chk("t6_stall_pre", 32'(stall), 32'd1);
    #1; rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t6_rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("t6_rst_stall",    32'(stall),    32'd0);
    chk("t6_rst_dest_s",   32'(dest_s),   32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      rst = ($urandom_range(63) == 0);
      cyc();
    end
    rst = 0; idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
